iq_demod_decim: RTL and testbench

Parametrised successor to the team's single-frequency IQ mixer/FIR chain: one synchronous I/Q lock-in demodulator with an internal quarter-wave NCO and a programmable phase offset. Each channel also has an accumulate-and-dump decimator and a valid/ready result port. It sits between the ADC sample stream and the display/host logic. It replaces the external NCO, mixer and FIR filter IP with fully specified, width-generic RTL.

---
 rtl/iq_demod_pkg.sv | 28 ++
 rtl/iq_nco_lut.sv | 53 +++++
 rtl/iq_demod_decim.sv | 196 +++++++++++++++++++
 tb/tb_iq_demod_decim.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/iq_demod_pkg.sv
// Shared types and elaboration-time helpers for the IQ lock-in demodulator/decimator.
package iq_demod_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

    localparam real PI = 3.14159265358979323846;

    function automatic int amp(input int data_w);
        return (1 << (data_w - 1)) - 1;
    endfunction

    function automatic int acc_width(input int data_w, input int log2_decim);
        return 2 * data_w + log2_decim;
    endfunction

    // First-quadrant sine table entry k; int'() on a real rounds to nearest.
    function automatic int quarter_sin(input int data_w, input int lut_aw, input int k);
        real ang;
        ang = 2.0 * PI * real'(k) / real'(1 << lut_aw);
        return int'(real'(amp(data_w)) * $sin(ang));
    endfunction

endpackage

// File: rtl/iq_nco_lut.sv
// Quarter-wave sine ROM with quadrant folding; registered signed cos/sin, one cycle of latency.
module iq_nco_lut
    import iq_demod_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int LUT_AW = 10
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [DATA_W-1:0] cos_val,
    output logic signed [DATA_W-1:0] sin_val
);

    localparam int QN = 1 << (LUT_AW - 2);
    localparam logic signed [DATA_W-1:0] AMP = DATA_W'(amp(DATA_W));

    logic signed [DATA_W-1:0] rom [QN];

    for (genvar k = 0; k < QN; k++) begin : g_rom
        assign rom[k] = DATA_W'(quarter_sin(DATA_W, LUT_AW, k));
    end

    quad_e                    quad;
    logic [LUT_AW-3:0]        idx;
    logic [LUT_AW-3:0]        ridx;
    logic signed [DATA_W-1:0] s_phi;
    logic signed [DATA_W-1:0] c_phi;

    // cos(phi) = sin(90 - phi); the table stops short of 90 degrees, so idx 0 maps to A.
    always_comb begin
        quad  = quad_e'(addr[LUT_AW-1 -: 2]);
        idx   = addr[LUT_AW-3:0];
        ridx  = '0 - idx;
        s_phi = rom[idx];
        c_phi = (idx == '0) ? AMP : rom[ridx];
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cos_val <= '0;
            sin_val <= '0;
        end else begin
            case (quad)
                QUAD_0: begin cos_val <= c_phi;  sin_val <= s_phi;  end
                QUAD_1: begin cos_val <= -s_phi; sin_val <= c_phi;  end
                QUAD_2: begin cos_val <= -c_phi; sin_val <= -s_phi; end
                default: begin cos_val <= s_phi; sin_val <= -c_phi; end
            endcase
        end
    end

endmodule

// File: rtl/iq_demod_decim.sv
// IQ lock-in demodulator with internal NCO and accumulate-and-dump decimation.
// Optional magnitude output stage enabled by defining IQ_DEMOD_MAG_EN.
module iq_demod_decim
    import iq_demod_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int PHASE_W    = 32,
    parameter int LUT_AW     = 10,
    parameter int LOG2_DECIM = 6
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [PHASE_W-1:0]       phase_inc,
    input  logic [PHASE_W-1:0]       phase_offset,
    input  logic                     phase_load,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_i,
    output logic signed [DATA_W-1:0] out_q,
`ifdef IQ_DEMOD_MAG_EN
    output logic signed [DATA_W-1:0] out_mag,
`endif
    output logic                     overrun
);

    localparam int ACC_W = acc_width(DATA_W, LOG2_DECIM);
    localparam int SHIFT = DATA_W - 1 + LOG2_DECIM;

    logic [PHASE_W-1:0]         ph;
    logic [LUT_AW-1:0]          cur_addr;
    logic [LUT_AW-1:0]          s0_addr;
    logic signed [DATA_W-1:0]   s0_data;
    logic                       s0_v;
    logic signed [DATA_W-1:0]   s1_cos;
    logic signed [DATA_W-1:0]   s1_sin;
    logic signed [DATA_W-1:0]   s1_data;
    logic                       s1_v;
    logic signed [2*DATA_W-1:0] s2_pi;
    logic signed [2*DATA_W-1:0] s2_pq;
    logic                       s2_v;
    logic signed [ACC_W-1:0]    acc_i;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    sum_i;
    logic signed [ACC_W-1:0]    sum_q;
    logic [LOG2_DECIM-1:0]      count;
    logic                       dump;
    logic signed [DATA_W-1:0]   res_i;
    logic signed [DATA_W-1:0]   res_q;
    logic                       res_v;
    logic                       res_fire;
    logic                       load;

    // A sample arriving with phase_load already uses the new offset as its phase.
    assign cur_addr = phase_load ? phase_offset[PHASE_W-1 -: LUT_AW] : ph[PHASE_W-1 -: LUT_AW];

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ph      <= '0;
            s0_addr <= '0;
            s0_data <= '0;
            s0_v    <= 1'b0;
        end else begin
            if (phase_load)
                ph <= phase_offset + (in_valid ? phase_inc : '0);
            else if (in_valid)
                ph <= ph + phase_inc;
            s0_v <= in_valid;
            if (in_valid) begin
                s0_addr <= cur_addr;
                s0_data <= in_data;
            end
        end
    end

    iq_nco_lut #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_nco (
        .CLK     (CLK),
        .reset_n (reset_n),
        .addr    (s0_addr),
        .cos_val (s1_cos),
        .sin_val (s1_sin)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            s1_data <= '0;
            s1_v    <= 1'b0;
            s2_pi   <= '0;
            s2_pq   <= '0;
            s2_v    <= 1'b0;
        end else begin
            s1_data <= s0_data;
            s1_v    <= s0_v && !phase_load;
            s2_pi   <= s1_data * s1_cos;
            s2_pq   <= s1_data * s1_sin;
            s2_v    <= s1_v && !phase_load;
        end
    end

    always_comb begin
        sum_i = acc_i + ACC_W'(s2_pi);
        sum_q = acc_q + ACC_W'(s2_pq);
        dump  = s2_v && !phase_load && (count == '1);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            acc_i <= '0;
            acc_q <= '0;
            count <= '0;
        end else if (phase_load) begin
            acc_i <= '0;
            acc_q <= '0;
            count <= '0;
        end else if (s2_v) begin
            count <= count + 1'b1;
            acc_i <= dump ? '0 : sum_i;
            acc_q <= dump ? '0 : sum_q;
        end
    end

`ifdef IQ_DEMOD_MAG_EN
    logic [DATA_W-1:0]        abs_i;
    logic [DATA_W-1:0]        abs_q;
    logic [DATA_W-1:0]        mx;
    logic [DATA_W-1:0]        mn;
    logic [DATA_W:0]          mag_sum;
    logic signed [DATA_W-1:0] mag_val;

    // Extra register stage between the dump and the output register for the magnitude path.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            res_v <= 1'b0;
            res_i <= '0;
            res_q <= '0;
        end else begin
            res_v <= dump;
            if (dump) begin
                res_i <= sum_i[SHIFT +: DATA_W];
                res_q <= sum_q[SHIFT +: DATA_W];
            end
        end
    end

    always_comb begin
        abs_i   = res_i[DATA_W-1] ? DATA_W'(-res_i) : DATA_W'(res_i);
        abs_q   = res_q[DATA_W-1] ? DATA_W'(-res_q) : DATA_W'(res_q);
        mx      = (abs_i > abs_q) ? abs_i : abs_q;
        mn      = (abs_i > abs_q) ? abs_q : abs_i;
        mag_sum = {1'b0, mx} + (DATA_W+1)'(mn >> 1);
        mag_val = (mag_sum > (DATA_W+1)'(amp(DATA_W))) ? DATA_W'(amp(DATA_W))
                                                       : signed'(mag_sum[DATA_W-1:0]);
    end
`else
    always_comb begin
        res_v = dump;
        res_i = sum_i[SHIFT +: DATA_W];
        res_q = sum_q[SHIFT +: DATA_W];
    end
`endif

    assign res_fire = res_v && !phase_load;
    assign load     = res_fire && (!out_valid || out_ready);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
`ifdef IQ_DEMOD_MAG_EN
            out_mag   <= '0;
`endif
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_i     <= res_i;
                out_q     <= res_q;
`ifdef IQ_DEMOD_MAG_EN
                out_mag   <= mag_val;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (phase_load)
                overrun <= 1'b0;
            else if (res_fire && !load)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iq_demod_decim.sv
// Directed self-checking bench for iq_demod_decim: DC gain, quadrature, tone lock,
// backpressure/overrun, mid-window phase_load and asynchronous reset.
module tb_iq_demod_decim;

    logic               CLK = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic signed [13:0] in_data;
    logic [31:0]        phase_inc;
    logic [31:0]        phase_offset;
    logic               phase_load;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] out_i;
    logic signed [13:0] out_q;
`ifdef IQ_DEMOD_MAG_EN
    logic signed [13:0] out_mag;
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    logic               overrun;

    int checks = 0;
    int fails  = 0;
    int tone [64];

    iq_demod_decim dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .phase_inc    (phase_inc),
        .phase_offset (phase_offset),
        .phase_load   (phase_load),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_i        (out_i),
        .out_q        (out_q),
`ifdef IQ_DEMOD_MAG_EN
        .out_mag      (out_mag),
`endif
        .overrun      (overrun)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: inputs set before the edge, returns 1 time unit after it.
    task automatic applyStimulus(input logic v, input int d, input logic ld, input logic rdy);
        in_valid   = v;
        in_data    = 14'(d);
        phase_load = ld;
        out_ready  = rdy;
        @(posedge CLK);
        #1;
        in_valid   = 1'b0;
        phase_load = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic feedConst(input int d, input int n, input logic ld_first);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b1, d, ld_first && (k == 0), 1'b0);
    endtask

    // Last sample was just accepted: result must land exactly 3 (+EXTRA) edges later.
    task automatic awaitResult(input string tag);
        for (int k = 0; k < 2 + EXTRA; k++)
            applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput({tag, "_not_early"}, int'(out_valid), 0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput({tag, "_valid"}, int'(out_valid), 1);
    endtask

    task automatic consume(input string tag);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput({tag, "_consumed"}, int'(out_valid), 0);
    endtask

    initial begin
        int windows;
        logic early;

        for (int k = 0; k < 64; k++)
            tone[k] = int'(8000.0 * $cos(2.0 * 3.14159265358979 * real'(k) / 64.0));

        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        phase_inc    = '0;
        phase_offset = '0;
        phase_load   = 1'b0;
        out_ready    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_i", int'(out_i), 0);
        checkOutput("reset_out_q", int'(out_q), 0);
        checkOutput("reset_overrun", int'(overrun), 0);
        reset_n = 1'b1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);

        $display("[TB] DC gain");
        phase_inc    = 32'h0;
        phase_offset = 32'h0;
        feedConst(1000, 64, 1'b1);
        awaitResult("dc");
        checkOutput("dc_out_i", int'(out_i), 999);
        checkOutput("dc_out_q", int'(out_q), 0);
`ifdef IQ_DEMOD_MAG_EN
        checkOutput("dc_out_mag", int'(out_mag), 999);
`endif
        consume("dc");

        $display("[TB] Quadrature");
        phase_offset = 32'h4000_0000;
        feedConst(1000, 64, 1'b1);
        awaitResult("quad");
        checkOutput("quad_out_i", int'(out_i), 0);
        checkOutput("quad_out_q", int'(out_q), 999);
        consume("quad");

        $display("[TB] Tone lock");
        phase_offset = 32'h0;
        phase_inc    = 32'h0400_0000;
        windows      = 0;
        for (int k = 0; k < 192 + 4 + EXTRA; k++) begin
            applyStimulus(k < 192, (k < 192) ? tone[k % 64] : 0, k == 0, 1'b1);
            if (out_valid) begin
                windows++;
                checkOutput("tone_i_in_range", int'(out_i >= 3998 && out_i <= 4002), 1);
                checkOutput("tone_q_in_range", int'(out_q >= -2 && out_q <= 2), 1);
            end
        end
        checkOutput("tone_windows", windows, 3);
        phase_inc = 32'h0;

        $display("[TB] Backpressure");
        feedConst(1000, 64, 1'b1);
        feedConst(500, 64, 1'b0);
        for (int k = 0; k < 3 + EXTRA; k++)
            applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput("bp_held_valid", int'(out_valid), 1);
        checkOutput("bp_held_i", int'(out_i), 999);
        checkOutput("bp_overrun_set", int'(overrun), 1);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("bp_overrun_cleared", int'(overrun), 0);
        checkOutput("bp_load_keeps_valid", int'(out_valid), 1);
        checkOutput("bp_load_keeps_i", int'(out_i), 999);
        consume("bp");

        $display("[TB] Load mid-window");
        feedConst(-2000, 30, 1'b1);
        early = 1'b0;
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b1, 1000, k == 0, 1'b0);
            if (out_valid) early = 1'b1;
        end
        checkOutput("midload_no_early_dump", int'(early), 0);
        awaitResult("midload");
        checkOutput("midload_out_i", int'(out_i), 999);
        checkOutput("midload_out_q", int'(out_q), 0);
        consume("midload");

        $display("[TB] Async reset");
        feedConst(1000, 64, 1'b1);
        awaitResult("pre_reset");
        feedConst(1000, 20, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_out_valid", int'(out_valid), 0);
        checkOutput("areset_out_i", int'(out_i), 0);
        checkOutput("areset_out_q", int'(out_q), 0);
        checkOutput("areset_overrun", int'(overrun), 0);
        @(posedge CLK);
        #3;
        reset_n = 1'b1;
        @(posedge CLK);
        #1;
        early = 1'b0;
        for (int k = 0; k < 64; k++) begin
            applyStimulus(1'b1, 1000, 1'b0, 1'b0);
            if (out_valid) early = 1'b1;
        end
        checkOutput("post_reset_no_early_dump", int'(early), 0);
        awaitResult("post_reset");
        checkOutput("post_reset_out_i", int'(out_i), 999);
        checkOutput("post_reset_out_q", int'(out_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
